// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS/CTRL bit positions, transmitter state encoding and the divisor helper.
package mmio_uart_tx_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIVL   = 3'd3;
  localparam logic [2:0] REG_DIVH   = 3'd4;
  localparam logic [15:0] NUM_REGS  = 16'd5;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IRQ   = 7;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txstate_t;

  // A zero divisor would stall the bit timer, so it behaves as one clock per bit.
  function automatic logic [15:0] div_eff(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Byte FIFO with zero-latency head output; a push and a pop in the same cycle
// are both honoured even when full.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // When full, the slot being written is the one being popped; the pop reads the old byte.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, control/status registers,
// transmit FIFO and a registered serializer driving tx.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'hD000,
  parameter int          DEPTH   = 4,
  parameter logic [15:0] DIV_RST = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rW,
  output logic [7:0]  rdata,
  output logic        tx,
  output logic        tx_irq
);
  logic [15:0] w_off;
  logic        w_sel;
  logic [2:0]  w_reg;
  logic        w_wr;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_fifo_rdata;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;

  logic [1:0]  r_ctrl;
  logic [15:0] r_div;
  logic        r_ovf;
  logic        r_irq;

  txstate_t    r_state, w_nxt_state;
  logic [15:0] r_baud, w_nxt_baud;
  logic [2:0]  r_bitcnt, w_nxt_bitcnt;
  logic [7:0]  r_shift, w_nxt_shift;
  logic        r_tx, w_nxt_tx;
  logic        w_tick;
  logic        w_start_ok;
  logic [15:0] w_reload;

  // Offsets below BASE wrap to large values, so one compare covers both bounds.
  assign w_off  = addr - BASE;
  assign w_sel  = (w_off < NUM_REGS);
  assign w_reg  = w_off[2:0];
  assign w_wr   = w_sel & ~rW;
  assign w_push = w_wr & (w_reg == REG_DATA);
  assign w_busy = (r_state != TX_IDLE);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (wdata),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= 2'b00;
      r_div  <= DIV_RST;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr && w_reg == REG_CTRL) r_ctrl <= wdata[1:0];
      if (w_wr && w_reg == REG_DIVL) r_div[7:0] <= wdata;
      if (w_wr && w_reg == REG_DIVH) r_div[15:8] <= wdata;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr && w_reg == REG_STATUS && wdata[ST_OVF]) r_ovf <= 1'b0;
    end
  end

  assign w_tick     = (r_baud == 16'd0);
  assign w_start_ok = r_ctrl[CTRL_TX_EN] & ~w_empty;
  assign w_reload   = div_eff(r_div) - 16'd1;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_baud   = r_baud;
    w_nxt_bitcnt = r_bitcnt;
    w_nxt_shift  = r_shift;
    w_nxt_tx     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (w_start_ok) begin
          w_nxt_state = TX_START;
          w_pop       = 1'b1;
          w_nxt_shift = w_fifo_rdata;
          w_nxt_baud  = w_reload;
          w_nxt_tx    = 1'b0;
        end else begin
          w_nxt_tx    = 1'b1;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_nxt_state  = TX_DATA;
          w_nxt_baud   = w_reload;
          w_nxt_bitcnt = 3'd0;
          w_nxt_tx     = r_shift[0];
        end else begin
          w_nxt_baud   = r_baud - 16'd1;
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          w_nxt_baud = w_reload;
          if (r_bitcnt == 3'd7) begin
            w_nxt_state = TX_STOP;
            w_nxt_tx    = 1'b1;
          end else begin
            w_nxt_bitcnt = r_bitcnt + 3'd1;
            w_nxt_shift  = {1'b0, r_shift[7:1]};
            w_nxt_tx     = r_shift[1];
          end
        end else begin
          w_nxt_baud = r_baud - 16'd1;
        end
      end
      TX_STOP: begin
        // Chaining straight into START keeps consecutive frames gap-free.
        if (w_tick) begin
          if (w_start_ok) begin
            w_nxt_state = TX_START;
            w_pop       = 1'b1;
            w_nxt_shift = w_fifo_rdata;
            w_nxt_baud  = w_reload;
            w_nxt_tx    = 1'b0;
          end else begin
            w_nxt_state = TX_IDLE;
            w_nxt_tx    = 1'b1;
          end
        end else begin
          w_nxt_baud = r_baud - 16'd1;
        end
      end
      default: begin
        w_nxt_state = TX_IDLE;
        w_nxt_tx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= TX_IDLE;
      r_baud   <= 16'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_tx     <= 1'b1;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_baud   <= w_nxt_baud;
      r_bitcnt <= w_nxt_bitcnt;
      r_shift  <= w_nxt_shift;
      r_tx     <= w_nxt_tx;
      r_irq    <= r_ctrl[CTRL_IRQ_EN] & w_empty & ~w_busy;
    end
  end

  assign tx     = r_tx;
  assign tx_irq = r_irq;

  always_comb begin
    rdata = 8'h00;
    if (w_sel && rW) begin
      case (w_reg)
        REG_STATUS: rdata = {r_irq, 3'b000, r_ovf, w_busy, w_empty, w_full};
        REG_CTRL:   rdata = {6'b000000, r_ctrl};
        REG_DIVL:   rdata = r_div[7:0];
        REG_DIVH:   rdata = r_div[15:8];
        default:    rdata = 8'h00;
      endcase
    end else begin
      rdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-access vector table followed by
// directed frame, FIFO-overflow, interrupt and mid-frame reset sequences.
module tb_mmio_uart_tx;
  localparam logic [15:0] BASE = 16'hD000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        rW = 1'b1;
  logic [7:0]  rdata;
  logic        tx;
  logic        tx_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k;
  logic [7:0] fr [8];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [19];

  mmio_uart_tx #(.BASE(16'hD000), .DEPTH(4), .DIV_RST(16'd104)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .rW     (rW),
    .rdata  (rdata),
    .tx     (tx),
    .tx_irq (tx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; rW = 1'b0;
    @(negedge clk);
    rW = 1'b1; addr = 16'h0000;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    addr = a; rW = 1'b1;
    #1 check(name, rdata, exp);
  endtask

  // Follows n frames from fr[] whose first START begins at the next clock edge.
  task automatic watch(input int n, input logic [7:0] stat1, input string tag);
    logic [9:0] fw;
    int idx;
    for (int j = 1; j <= n * 40; j++) begin
      @(negedge clk);
      addr = BASE + 16'd1; rW = 1'b1;
      #1;
      idx = (j - 1) / 4;
      fw = {1'b1, fr[idx / 10], 1'b0};
      check($sformatf("%s tx j=%0d", tag, j), tx, fw[idx % 10]);
      check($sformatf("%s busy j=%0d", tag, j), rdata[2], 1'b1);
      if (j == 1) check($sformatf("%s status first", tag), rdata, stat1);
    end
    @(negedge clk);
    #1;
    check($sformatf("%s idle tx", tag), tx, 1'b1);
    check($sformatf("%s idle status", tag), rdata, 8'h02);
  endtask

  initial begin
    vecs[0]  = '{BASE + 16'd1, 8'h00, 1'b1, 8'h02};
    vecs[1]  = '{BASE + 16'd2, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{BASE + 16'd3, 8'h00, 1'b1, 8'h68};
    vecs[3]  = '{BASE + 16'd4, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{16'h0200,     8'h00, 1'b1, 8'h00};
    vecs[5]  = '{BASE,         8'h00, 1'b1, 8'h00};
    vecs[6]  = '{BASE + 16'd3, 8'h04, 1'b0, 8'h00};
    vecs[7]  = '{BASE + 16'd3, 8'h00, 1'b1, 8'h04};
    vecs[8]  = '{BASE + 16'd2, 8'hFF, 1'b0, 8'h00};
    vecs[9]  = '{BASE + 16'd2, 8'h00, 1'b1, 8'h03};
    vecs[10] = '{BASE + 16'd1, 8'h00, 1'b1, 8'h82};
    vecs[11] = '{BASE + 16'd5, 8'h55, 1'b0, 8'h00};
    vecs[12] = '{BASE + 16'd5, 8'h00, 1'b1, 8'h00};
    vecs[13] = '{BASE + 16'd2, 8'h00, 1'b0, 8'h00};
    vecs[14] = '{BASE + 16'd2, 8'h00, 1'b1, 8'h00};
    vecs[15] = '{BASE + 16'd1, 8'hFF, 1'b0, 8'h00};
    vecs[16] = '{BASE + 16'd1, 8'h00, 1'b1, 8'h02};
    vecs[17] = '{16'hCFFF,     8'h12, 1'b0, 8'h00};
    vecs[18] = '{BASE + 16'd1, 8'h00, 1'b1, 8'h02};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset tx", tx, 1'b1);
    check("reset irq", tx_irq, 1'b0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      addr = vecs[i].a; wdata = vecs[i].d; rW = vecs[i].rw;
      #1 check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp);
    end

    // Single frame of A5 at 4 clocks per bit.
    wr(BASE + 16'd2, 8'h01);
    fr[0] = 8'hA5;
    @(negedge clk);
    addr = BASE; wdata = 8'hA5; rW = 1'b0;
    @(negedge clk);
    addr = BASE + 16'd1; rW = 1'b1;
    #1;
    check("frame1 pre tx", tx, 1'b1);
    check("frame1 pre status", rdata, 8'h00);
    watch(1, 8'h06, "frame1");

    // Overflow, ovf clear, then four chained frames.
    wr(BASE + 16'd2, 8'h00);
    fr[0] = 8'h3C; fr[1] = 8'hC3; fr[2] = 8'h81; fr[3] = 8'h7E;
    for (int i = 0; i < 4; i++) wr(BASE, fr[i]);
    wr(BASE, 8'hFF);
    rd_chk("ovf status", BASE + 16'd1, 8'h09);
    wr(BASE + 16'd1, 8'h08);
    rd_chk("ovf cleared", BASE + 16'd1, 8'h01);
    @(negedge clk);
    addr = BASE + 16'd2; wdata = 8'h01; rW = 1'b0;
    @(negedge clk);
    addr = BASE + 16'd1; rW = 1'b1;
    #1;
    check("burst pre tx", tx, 1'b1);
    check("burst pre status", rdata, 8'h01);
    watch(4, 8'h04, "burst");

    // Push into a full FIFO on the same edge the STOP->START pop happens.
    wr(BASE, 8'h11);
    k = cyc;
    fr[0] = 8'h22; fr[1] = 8'h33; fr[2] = 8'h44; fr[3] = 8'h55; fr[4] = 8'h66;
    for (int i = 0; i < 4; i++) wr(BASE, fr[i]);
    addr = BASE + 16'd1; rW = 1'b1;
    #1 check("full in frame status", rdata, 8'h05);
    while (cyc != k + 40) @(negedge clk);
    addr = BASE; wdata = 8'h66; rW = 1'b0;
    watch(5, 8'h05, "poppush");

    // Transmit-complete interrupt.
    wr(BASE + 16'd2, 8'h03);
    @(negedge clk);
    #1 check("irq idle", tx_irq, 1'b1);
    addr = BASE; wdata = 8'h5A; rW = 1'b0;
    for (int j = 0; j <= 42; j++) begin
      @(negedge clk);
      addr = BASE + 16'd1; rW = 1'b1;
      #1 check($sformatf("irq j=%0d", j), tx_irq, (j == 0 || j == 42) ? 1'b1 : 1'b0);
      if (j == 42) check("irq status", rdata, 8'h82);
    end

    // Reset during data bit 4 of 0F with a second byte queued.
    wr(BASE + 16'd2, 8'h01);
    wr(BASE, 8'h0F);
    k = cyc;
    wr(BASE, 8'hF0);
    while (cyc != k + 22) @(negedge clk);
    #1 check("pre-reset tx", tx, 1'b0);
    rst = 1'b1;
    #1 check("async reset tx", tx, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_chk("post-reset status", BASE + 16'd1, 8'h02);
    rd_chk("post-reset divl", BASE + 16'd3, 8'h68);
    rd_chk("post-reset divh", BASE + 16'd4, 8'h00);
    rd_chk("post-reset ctrl", BASE + 16'd2, 8'h00);
    begin
      int lows = 0;
      for (int j = 0; j < 50; j++) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
      end
      check("no residual frame", lows, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
